// File: rtl/seqdetect_arbiter.sv
// rtl/seqdetect_arbiter.sv - round-robin scheduler sharing one 1011 sequence detector
//
// Grants one requester at a time, pulses the detector reset, shifts the latched
// frame word into the detector MSB-first and reports the hit count per frame.
//
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   req         - per-requester frame request (N_REQ)
//   data        - frame words, requester i at [i*FRAME_W +: FRAME_W]
//   grant       - one-hot grant, zero when idle
//   busy        - high whenever not idle
//   det_reset   - detector reset (system reset or flush)
//   det_bit     - detector serial input
//   det_seen    - detector seq_seen, reflects the bit applied one cycle earlier
//   done        - one-cycle frame-result pulse
//   done_id     - finished requester index
//   hit         - at least one detection in the frame
//   hit_cnt     - detections in the frame, saturating at 15
module seqdetect_arbiter #(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   data,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    output logic                       det_reset,
    output logic                       det_bit,
    input  logic                       det_seen,
    output logic                       done,
    output logic [$clog2(N_REQ)-1:0]   done_id,
    output logic                       hit,
    output logic [3:0]                 hit_cnt
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int IDX_W = $clog2(FRAME_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     last;
    logic [FRAME_W-1:0]  sreg;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          cnt;
    logic [3:0]          cnt_fin;
    logic                any_req;
    logic                found;
    logic [ID_W-1:0]     win;
    logic [ID_W-1:0]     cand;

    // Rotating-priority search starting just after the last winner.
    always_comb begin
        any_req = |req;
        found   = 1'b0;
        win     = last;
        cand    = last;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Final count including the DRAIN sample, which covers the last frame bit.
    always_comb begin
        cnt_fin = cnt;
        if (det_seen && cnt != 4'hF) begin
            cnt_fin = cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = FLUSH;
            FLUSH:   state_nxt = SHIFT;
            SHIFT:   if (idx == IDX_W'(FRAME_W - 1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        det_reset = reset || (state == FLUSH);
        det_bit   = (state == SHIFT) ? sreg[FRAME_W-1] : 1'b0;
        done      = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant   <= '0;
            last    <= ID_W'(N_REQ - 1);
            sreg    <= '0;
            idx     <= '0;
            cnt     <= '0;
            done_id <= '0;
            hit     <= 1'b0;
            hit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= N_REQ'(1) << win;
                        last  <= win;
                        sreg  <= data[int'(win)*FRAME_W +: FRAME_W];
                        cnt   <= '0;
                    end
                end
                FLUSH: begin
                    idx <= '0;
                end
                SHIFT: begin
                    sreg <= {sreg[FRAME_W-2:0], 1'b0};
                    idx  <= idx + IDX_W'(1);
                    // Shift cycle 0 sees the post-reset detector state; skip it.
                    if (idx != '0 && det_seen && cnt != 4'hF) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    done_id <= last;
                    hit_cnt <= cnt_fin;
                    hit     <= (cnt_fin != 4'd0);
                end
                DONE: begin
                    grant <= '0;
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seqdetect_arbiter.sv
// tb/tb_seqdetect_arbiter.sv - self-checking bench for seqdetect_arbiter
module tb_seqdetect_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        busy;
    logic        det_reset;
    logic        det_bit;
    logic        det_seen;
    logic        done;
    logic [1:0]  done_id;
    logic        hit;
    logic [3:0]  hit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seqdetect_arbiter #(.N_REQ(4), .FRAME_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .grant     (grant),
        .busy      (busy),
        .det_reset (det_reset),
        .det_bit   (det_bit),
        .det_seen  (det_seen),
        .done      (done),
        .done_id   (done_id),
        .hit       (hit),
        .hit_cnt   (hit_cnt)
    );

    // Non-overlapping 1011 detector: 0=idle 1="1" 2="10" 3="101" 4=seen.
    int dstate;
    always_ff @(posedge clk) begin
        if (det_reset) begin
            dstate <= 0;
        end else begin
            case (dstate)
                0:       dstate <= det_bit ? 1 : 0;
                1:       dstate <= det_bit ? 1 : 2;
                2:       dstate <= det_bit ? 3 : 0;
                3:       dstate <= det_bit ? 4 : 2;
                default: dstate <= 0;
            endcase
        end
    end
    assign det_seen = (dstate == 4);

    function automatic logic [3:0] exp_count(input logic [7:0] w);
        int st = 0;
        int c = 0;
        for (int b = 7; b >= 0; b--) begin
            case (st)
                0:       st = w[b] ? 1 : 0;
                1:       st = w[b] ? 1 : 2;
                2:       st = w[b] ? 3 : 0;
                3:       st = w[b] ? 4 : 2;
                default: st = 0;
            endcase
            if (st == 4 && c < 15) c++;
        end
        return 4'(c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard: done with no expected entry");
        end else begin
            e = sb.pop_front();
            chk("done_id", 32'(done_id), 32'(e.id));
            chk("hit_cnt", 32'(hit_cnt), 32'(e.cnt));
            chk("hit", 32'(hit), 32'(e.cnt != 4'd0));
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 40);
        if (!done) begin
            n_cmp++;
            n_bad++;
            $error("FAIL done_timeout: observed no done after %0d cycles", cycles);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Single-requester frame with cycle-by-cycle checks from grant to done.
    task automatic do_frame(input int id, input logic [7:0] word);
        data[id*8 +: 8] = word;
        req = 4'(1) << id;
        sb.push_back('{id: 2'(id), cnt: exp_count(word)});
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("det_reset", 32'(det_reset), 32'(k == 1));
            chk("done", 32'(done), 32'(k == 11));
            if (k == 1) chk("grant", 32'(grant), 32'(1) << id);
            if (k == 2) data[id*8 +: 8] = ~word;
            if (k >= 2 && k <= 9) chk("det_bit", 32'(det_bit), 32'(word[9-k]));
        end
        if (done) begin
            pop_cmp();
            chk("grant_in_done", 32'(grant), 32'(1) << id);
        end
        req = '0;
        @(negedge clk);
        chk("idle_grant", 32'(grant), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("hold_id", 32'(done_id), 32'(id));
        chk("hold_cnt", 32'(hit_cnt), 32'(exp_count(word)));
    endtask

    initial begin
        int cyc;
        int ids[5];
        logic [7:0] w;
        reset = 1'b1;
        req   = '0;
        data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_det_reset", 32'(det_reset), 32'(1));
        chk("rst_det_bit", 32'(det_bit), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_done_id", 32'(done_id), 32'(0));
        chk("rst_hit", 32'(hit), 32'(0));
        chk("rst_hit_cnt", 32'(hit_cnt), 32'(0));
        reset = 1'b0;

        // Single request, no match, non-overlapping detection.
        do_frame(0, 8'b1011_0000);
        do_frame(2, 8'hFF);
        do_frame(1, 8'b1011_1011);
        do_frame(3, 8'b1101_1011);

        // Round-robin with all requesters held.
        do_reset();
        data = {8'b1101_1011, 8'h5A, 8'b0101_1000, 8'b1011_0000};
        ids  = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            w = data[ids[j]*8 +: 8];
            sb.push_back('{id: 2'(ids[j]), cnt: exp_count(w)});
        end
        req = 4'hF;
        for (int j = 0; j < 5; j++) begin
            wait_done(cyc);
            chk("rr_spacing", 32'(cyc), (j == 0) ? 32'd11 : 32'd12);
            chk("rr_grant", 32'(grant), 32'(1) << ids[j]);
            if (done) pop_cmp();
        end
        req = '0;

        // Rotation skip: last=1, req=1001 -> index 3 then 0.
        do_reset();
        do_frame(1, 8'hB0);
        data = {8'hB0, 8'h00, 8'h00, 8'h0B};
        sb.push_back('{id: 2'd3, cnt: exp_count(8'hB0)});
        sb.push_back('{id: 2'd0, cnt: exp_count(8'h0B)});
        req = 4'b1001;
        for (int j = 0; j < 2; j++) begin
            wait_done(cyc);
            chk("skip_grant", 32'(grant), (j == 0) ? 32'h8 : 32'h1);
            if (done) pop_cmp();
        end
        req = '0;

        // Reset in shift cycle 3 discards the frame.
        do_reset();
        data = {8'h00, 8'hB0, 8'h00, 8'hB0};
        req  = 4'b0100;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_det_reset", 32'(det_reset), 32'(1));
        chk("mid_rst_done", 32'(done), 32'(0));
        reset = 1'b0;
        req   = 4'b0011;
        sb.push_back('{id: 2'd0, cnt: exp_count(8'hB0)});
        wait_done(cyc);
        chk("post_rst_latency", 32'(cyc), 32'd11);
        chk("post_rst_grant", 32'(grant), 32'h1);
        if (done) pop_cmp();
        req = '0;
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
